// File: rtl/regression_monitor.sv
// rtl/regression_monitor.sv - write-bus snooping end-of-test checker with programmable (address, value) channels
// Optional first-failure capture on fail_chan/fail_data: define REGRESSION_MONITOR_TRACE_EN.
module regression_monitor #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 8,
    parameter int                NUM_CHECKS = 4,
    parameter int                CIDX_W     = 2,
    parameter int                CNT_W      = 20,
    parameter int                TIMEOUT    = 100,
    parameter logic [ADDR_W-1:0] DONE_ADDR  = 16'hFFF0
) (
    input  logic                  ph1,
    input  logic                  reset_b,
    input  logic                  cfg_we,
    input  logic [CIDX_W-1:0]     cfg_idx,
    input  logic                  cfg_en,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [DATA_W-1:0]     cfg_data,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     bus_addr,
    input  logic [DATA_W-1:0]     bus_data,
    input  logic                  bus_we,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [NUM_CHECKS-1:0] match_vec,
    output logic [CNT_W-1:0]      cycles,
    output logic [CIDX_W-1:0]     fail_chan,
    output logic [DATA_W-1:0]     fail_data
);
    typedef enum logic [1:0] {IDLE, RUN, EVAL, DONE} state_t;

    state_t                state, state_nx;
    logic [NUM_CHECKS-1:0] ch_en, written;
    logic [ADDR_W-1:0]     ch_addr [NUM_CHECKS];
    logic [DATA_W-1:0]     ch_exp  [NUM_CHECKS];
    logic [DATA_W-1:0]     last    [NUM_CHECKS];
    logic                  aborted, pass_r;
    logic [CNT_W-1:0]      cnt;
    logic                  idle_like, done_wr, timeout_hit, term;

    assign idle_like   = (state == IDLE) || (state == DONE);
    assign done_wr     = bus_we && (bus_addr == DONE_ADDR);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign term        = abort || done_wr || timeout_hit;

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN:        if (term)  state_nx = EVAL;
            EVAL:       state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < NUM_CHECKS; i++)
            match_vec[i] = ch_en[i] && written[i] && (last[i] == ch_exp[i]);
    end

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                ch_addr[i] <= '0;
                ch_exp[i]  <= '0;
                last[i]    <= '0;
            end
            ch_en   <= '0;
            written <= '0;
            cnt     <= '0;
            pass_r  <= 1'b0;
            aborted <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // cfg_idx values beyond NUM_CHECKS-1 match no entry and are dropped
                    if (cfg_we) begin
                        for (int i = 0; i < NUM_CHECKS; i++) begin
                            if (cfg_idx == CIDX_W'(i)) begin
                                ch_en[i]   <= cfg_en;
                                ch_addr[i] <= cfg_addr;
                                ch_exp[i]  <= cfg_data;
                            end
                        end
                    end
                    if (start) begin
                        for (int i = 0; i < NUM_CHECKS; i++) last[i] <= '0;
                        written <= '0;
                        cnt     <= '0;
                        pass_r  <= 1'b0;
                        aborted <= 1'b0;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (abort) aborted <= 1'b1;
                    if (bus_we) begin
                        for (int i = 0; i < NUM_CHECKS; i++) begin
                            if (ch_en[i] && (ch_addr[i] == bus_addr)) begin
                                last[i]    <= bus_data;
                                written[i] <= 1'b1;
                            end
                        end
                    end
                end
                EVAL: pass_r <= !aborted && (|ch_en) && ((match_vec & ch_en) == ch_en);
                default: ;
            endcase
        end
    end

    assign busy   = (state == RUN) || (state == EVAL);
    assign done   = (state == DONE);
    assign pass   = pass_r;
    assign cycles = cnt;

`ifdef REGRESSION_MONITOR_TRACE_EN
    logic [CIDX_W-1:0] fchan_r, fchan_nx;
    logic [DATA_W-1:0] fdata_r, fdata_nx;

    // Descending scan so the lowest failing index wins; a passing run finds nothing and yields 0
    always_comb begin
        fchan_nx = '0;
        fdata_nx = '0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (ch_en[i] && !match_vec[i]) begin
                fchan_nx = CIDX_W'(i);
                fdata_nx = last[i];
            end
        end
    end

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            fchan_r <= '0;
            fdata_r <= '0;
        end else if (idle_like && start) begin
            fchan_r <= '0;
            fdata_r <= '0;
        end else if (state == EVAL) begin
            fchan_r <= fchan_nx;
            fdata_r <= fdata_nx;
        end
    end

    assign fail_chan = fchan_r;
    assign fail_data = fdata_r;
`else
    assign fail_chan = '0;
    assign fail_data = '0;
`endif
endmodule

// File: tb/tb_regression_monitor.sv
// tb/tb_regression_monitor.sv - randomized self-checking bench for regression_monitor against a behavioural model
module tb_regression_monitor;
    localparam int AW = 16, DW = 8, NC = 4, CW = 2, NW = 20, TO = 100;
    localparam logic [AW-1:0] DA = 16'hFFF0;
`ifdef REGRESSION_MONITOR_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic          ph1 = 1'b0, reset_b = 1'b0;
    logic          cfg_we = 0, cfg_en = 0, start = 0, abort = 0, bus_we = 0;
    logic [CW-1:0] cfg_idx = '0;
    logic [AW-1:0] cfg_addr = '0, bus_addr = '0;
    logic [DW-1:0] cfg_data = '0, bus_data = '0;
    logic          busy, done, pass;
    logic [NC-1:0] match_vec;
    logic [NW-1:0] cycles;
    logic [CW-1:0] fail_chan;
    logic [DW-1:0] fail_data;

    regression_monitor dut (
        .ph1(ph1), .reset_b(reset_b), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .abort(abort),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we), .busy(busy), .done(done),
        .pass(pass), .match_vec(match_vec), .cycles(cycles), .fail_chan(fail_chan),
        .fail_data(fail_data)
    );

    always #5 ph1 = ~ph1;

    int checks = 0, errors = 0;

    logic          m_en   [NC];
    logic [AW-1:0] m_addr [NC];
    logic [DW-1:0] m_exp  [NC];
    logic [DW-1:0] m_last [NC];
    logic          m_wr   [NC];
    logic          m_abort;
    int            m_cycles;

    function automatic logic [NC-1:0] m_match();
        logic [NC-1:0] r = '0;
        for (int i = 0; i < NC; i++) r[i] = m_en[i] && m_wr[i] && (m_last[i] == m_exp[i]);
        return r;
    endfunction

    function automatic logic m_pass();
        logic [NC-1:0] mm = m_match();
        logic any = 1'b0, all = 1'b1;
        for (int i = 0; i < NC; i++) if (m_en[i]) begin any = 1'b1; if (!mm[i]) all = 1'b0; end
        return !m_abort && any && all;
    endfunction

    function automatic logic [CW+DW-1:0] m_trace();
        logic [NC-1:0] mm = m_match();
        if (!TRACE) return '0;
        for (int i = 0; i < NC; i++)
            if (m_en[i] && !mm[i]) return {CW'(i), (m_wr[i] ? m_last[i] : DW'(0))};
        return '0;
    endfunction

    task automatic step();
        @(posedge ph1);
        #1;
    endtask

    task automatic model_clear_cfg();
        for (int i = 0; i < NC; i++) begin
            m_en[i] = 0; m_addr[i] = '0; m_exp[i] = '0; m_last[i] = '0; m_wr[i] = 0;
        end
        m_abort = 0; m_cycles = 0;
    endtask

    task automatic cfg_write(input int idx, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_we = 1; cfg_idx = CW'(idx); cfg_en = en; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 0;
        m_en[idx] = en; m_addr[idx] = a; m_exp[idx] = d;
    endtask

    task automatic start_run();
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < NC; i++) begin m_last[i] = '0; m_wr[i] = 0; end
        m_abort = 0; m_cycles = 0;
    endtask

    task automatic run_cycle(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ab);
        bus_we = we; bus_addr = a; bus_data = d; abort = ab;
        step();
        bus_we = 0; abort = 0;
        m_cycles++;
        if (we) for (int i = 0; i < NC; i++)
            if (m_en[i] && m_addr[i] == a) begin m_last[i] = d; m_wr[i] = 1; end
        if (ab) m_abort = 1;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, pass, match_vec, cycles, fail_chan, fail_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b pass=%b mv=%b cyc=%0d fc=%0d fd=%h exp all 0",
                     busy, done, pass, match_vec, cycles, fail_chan, fail_data);
        end
    endtask

    task automatic test_basic_pass();
        for (int i = 0; i < NC; i++) cfg_write(i, 0, '0, '0);
        cfg_write(0, 1, 16'h0071, 8'hFF);
        start_run();
        run_cycle(1, 16'h0071, 8'hFF, 0);
        checks++;
        if (match_vec !== 4'b0001) begin errors++; $display("FAIL basic_match_live got %b exp 0001", match_vec); end
        run_cycle(1, DA, 8'h00, 0);
        checks++;
        if (busy !== 1 || done !== 0) begin errors++; $display("FAIL basic_eval got busy=%b done=%b exp 1 0", busy, done); end
        step();
        checks++;
        if (done !== 1 || pass !== 1 || match_vec !== 4'b0001 || cycles !== NW'(2)) begin
            errors++;
            $display("FAIL basic_done got done=%b pass=%b mv=%b cyc=%0d exp 1 1 0001 2", done, pass, match_vec, cycles);
        end
        checks++;
        if ({fail_chan, fail_data} !== '0) begin errors++; $display("FAIL basic_trace got %0d %h exp 0 00", fail_chan, fail_data); end
    endtask

    task automatic test_mismatch();
        cfg_write(1, 1, 16'h0072, 8'h00);
        start_run();
        run_cycle(1, 16'h0071, 8'hFF, 0);
        run_cycle(1, 16'h0071, 8'hFE, 0);
        checks++;
        if (match_vec !== 4'b0000) begin errors++; $display("FAIL mismatch_cleared got %b exp 0000", match_vec); end
        run_cycle(1, DA, 8'h00, 0);
        step();
        checks++;
        if (done !== 1 || pass !== 0 || match_vec !== 4'b0000) begin
            errors++; $display("FAIL mismatch_done got done=%b pass=%b mv=%b exp 1 0 0000", done, pass, match_vec);
        end
        checks++;
        if ({fail_chan, fail_data} !== (TRACE ? {2'd0, 8'hFE} : 10'd0)) begin
            errors++; $display("FAIL mismatch_trace got %0d %h", fail_chan, fail_data);
        end
    endtask

    task automatic test_timeout();
        cfg_write(1, 0, '0, '0);
        start_run();
        for (int k = 0; k < TO; k++) run_cycle(0, '0, '0, 0);
        checks++;
        if (busy !== 1 || done !== 0 || cycles !== NW'(TO)) begin
            errors++; $display("FAIL timeout_eval got busy=%b done=%b cyc=%0d exp 1 0 %0d", busy, done, cycles, TO);
        end
        step();
        checks++;
        if (done !== 1 || pass !== 0) begin errors++; $display("FAIL timeout_done got done=%b pass=%b exp 1 0", done, pass); end
        repeat (3) step();
        checks++;
        if (done !== 1 || cycles !== NW'(TO)) begin
            errors++; $display("FAIL timeout_hold got done=%b cyc=%0d exp 1 %0d", done, cycles, TO);
        end
    endtask

    task automatic test_no_channels();
        for (int i = 0; i < NC; i++) cfg_write(i, 0, '0, '0);
        start_run();
        cfg_we = 1; cfg_idx = 0; cfg_en = 1; cfg_addr = 16'h0071; cfg_data = 8'h11;
        run_cycle(0, '0, '0, 0);
        cfg_we = 0;
        run_cycle(1, 16'h0071, 8'h11, 0);
        checks++;
        if (match_vec !== 4'b0000) begin errors++; $display("FAIL run_cfg_ignored got %b exp 0000", match_vec); end
        run_cycle(1, DA, 8'h00, 0);
        step();
        checks++;
        if (done !== 1 || pass !== 0 || cycles !== NW'(3)) begin
            errors++; $display("FAIL no_channels got done=%b pass=%b cyc=%0d exp 1 0 3", done, pass, cycles);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < NC; i++) cfg_write(i, 1, AW'(16'h0100 + i), DW'($urandom));
        start_run();
        for (int i = 0; i < NC; i++) run_cycle(1, m_addr[i], m_exp[i], 0);
        checks++;
        if (match_vec !== 4'b1111) begin errors++; $display("FAIL abort_premat got %b exp 1111", match_vec); end
        run_cycle(0, '0, '0, 1);
        step();
        checks++;
        if (done !== 1 || pass !== 0 || cycles !== NW'(5) || match_vec !== 4'b1111) begin
            errors++; $display("FAIL abort_done got done=%b pass=%b cyc=%0d mv=%b exp 1 0 5 1111", done, pass, cycles, match_vec);
        end
        checks++;
        if ({fail_chan, fail_data} !== '0) begin errors++; $display("FAIL abort_trace got %0d %h exp 0 00", fail_chan, fail_data); end
    endtask

    task automatic test_reset_mid_run();
        cfg_write(0, 1, 16'h0071, 8'hFF);
        start_run();
        run_cycle(1, 16'h0071, 8'hFF, 0);
        run_cycle(0, '0, '0, 0);
        reset_b = 0;
        #1;
        checks++;
        if ({busy, done, pass, match_vec} !== '0) begin
            errors++; $display("FAIL reset_mid_run got busy=%b done=%b pass=%b mv=%b exp 0", busy, done, pass, match_vec);
        end
        step();
        reset_b = 1;
        model_clear_cfg();
        step();
        start_run();
        run_cycle(1, 16'h0071, 8'hFF, 0);
        run_cycle(1, DA, 8'h00, 0);
        step();
        checks++;
        if (done !== 1 || pass !== 0 || match_vec !== 4'b0000) begin
            errors++; $display("FAIL reset_cfg_lost got done=%b pass=%b mv=%b exp 1 0 0000", done, pass, match_vec);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int n;
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < NC; c++) begin
                a = ($urandom_range(0, 7) == 0) ? DA : AW'(16'h0010 + $urandom_range(0, 3));
                cfg_write(c, 1'($urandom_range(0, 1)), a, DW'($urandom_range(0, 3)));
            end
            start_run();
            n = $urandom_range(1, 20);
            for (int k = 0; k < n; k++) begin
                run_cycle(1'($urandom_range(0, 1)), AW'(16'h0010 + $urandom_range(0, 3)), DW'($urandom_range(0, 3)), 0);
                checks++;
                if (match_vec !== m_match() || busy !== 1) begin
                    errors++; $display("FAIL rand_live it=%0d k=%0d got mv=%b busy=%b exp %b 1", it, k, match_vec, busy, m_match());
                end
            end
            if ($urandom_range(0, 2) == 0)
                run_cycle(1'($urandom_range(0, 1)), AW'(16'h0010 + $urandom_range(0, 3)), DW'($urandom_range(0, 3)), 1);
            else
                run_cycle(1, DA, DW'($urandom_range(0, 3)), 0);
            step();
            checks++;
            if (done !== 1 || pass !== m_pass() || match_vec !== m_match() || cycles !== NW'(m_cycles)) begin
                errors++;
                $display("FAIL rand_done it=%0d got done=%b pass=%b mv=%b cyc=%0d exp 1 %b %b %0d",
                         it, done, pass, match_vec, cycles, m_pass(), m_match(), m_cycles);
            end
            checks++;
            if ({fail_chan, fail_data} !== m_trace()) begin
                errors++; $display("FAIL rand_trace it=%0d got %0d %h exp %h", it, fail_chan, fail_data, m_trace());
            end
        end
    endtask

    initial begin
        model_clear_cfg();
        repeat (3) step();
        test_reset();
        reset_b = 1;
        step();
        test_basic_pass();
        test_mismatch();
        test_timeout();
        test_no_channels();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regression_monitor.md
Name: regression_monitor

Overview:
- Parametrised on-chip successor to the fixed single-address RAM check done at end of each SuiteA test.
- Snoops the CPU/memory write bus and tracks up to NUM_CHECKS programmable (address, expected value) channels.
- Ends a test on a write to a done address or on a cycle timeout, then reports pass/fail, a per-channel match vector and the elapsed cycle count.
- Sits beside top.mem on the ph1 domain; benches read done/pass instead of peeking RAM after a fixed delay.

Parameters:
- ADDR_W, 16, bus address width
- DATA_W, 8, bus data width
- NUM_CHECKS, 4, number of check channels (>=1)
- CIDX_W, 2, channel index width (>= clog2(NUM_CHECKS), min 1)
- CNT_W, 20, cycle counter width
- TIMEOUT, 100, maximum RUN cycles before forced evaluation (1..2^CNT_W-1)
- DONE_ADDR, 16'hFFF0, bus write to this address terminates the test

Ports:
- ph1  in  1  single clock, rising edge
- reset_b  in  1  asynchronous active-low reset
- cfg_we  in  1  write config entry cfg_idx
- cfg_idx  in  CIDX_W  channel index
- cfg_en  in  1  channel enable
- cfg_addr  in  ADDR_W  watched address
- cfg_data  in  DATA_W  expected value
- start  in  1  begin monitoring
- abort  in  1  end test as fail
- bus_addr  in  ADDR_W  snooped address
- bus_data  in  DATA_W  snooped write data
- bus_we  in  1  snooped write strobe
- busy  out  1  high in RUN/EVAL
- done  out  1  high in DONE
- pass  out  1  result, valid while done
- match_vec  out  NUM_CHECKS  per-channel live match
- cycles  out  CNT_W  RUN cycles elapsed
- fail_chan  out  CIDX_W  see Optional Feature
- fail_data  out  DATA_W  see Optional Feature

Behaviour:
- Reset (async, any state): state IDLE; all cfg entries en=0/addr=0/exp=0; last/written cleared; all outputs 0.
- States: IDLE, RUN, EVAL, DONE.
  - IDLE/DONE + start -> RUN; clears last, written, cycles and pass.
  - RUN -> EVAL on abort, on bus_we & bus_addr==DONE_ADDR, or at the edge where cycles==TIMEOUT-1.
  - EVAL -> DONE after exactly 1 cycle.
  - DONE holds until start.
- cfg_we honoured only in IDLE/DONE; ignored in RUN/EVAL. Out-of-range cfg_idx is ignored.
- RUN write snooping: on bus_we, every enabled channel with cfg_addr==bus_addr loads last<=bus_data and sets written<=1.
  - Multiple channels on the same address all update.
  - The terminating DONE_ADDR write also updates matching channels.
- match_vec[i] = en & written & (last==exp); combinational from registers, so it updates 1 cycle after the write. A later differing write clears the match.
- cycles: +1 on every RUN cycle including the terminating one; holds in EVAL/DONE. A timeout run ends with cycles==TIMEOUT.
- EVAL computes pass = (no abort) & (at least one enabled channel) & (all enabled channels matched). Zero enabled channels -> fail.
- Latency: termination event sampled at edge k -> EVAL after k; done=1 and pass valid after edge k+1.
- Precedence: abort over DONE_ADDR write over timeout; all produce the same EVAL timing.
- start in RUN/EVAL and abort outside RUN are ignored.
- Reset mid-RUN: returns to IDLE and config is lost.

Optional Feature:
- Macro: REGRESSION_MONITOR_TRACE_EN.
- Defined: in EVAL, capture the lowest-index enabled, non-matching channel into fail_chan and its last value into fail_data (0 if never written). Both hold through DONE, are cleared on start, and read 0 on pass.
- Undefined: fail_chan and fail_data are tied to 0 and no capture registers are built.

Test Plan:
- cfg ch0 = (0x0071, 0xFF, en); start; write 0x71<-0xFF, then write 0xFFF0 -> done=1 two edges after the done write, pass=1, match_vec=0001.
- ch0 = (0x0071, 0xFF), ch1 = (0x0072, 0x00); write 0x71<-0xFF, then 0x71<-0xFE, then done write -> pass=0, match_vec=0000; with TRACE_EN fail_chan=0, fail_data=0xFE.
- ch0 enabled, no writes, TIMEOUT=100 -> done after 101 edges from start, cycles=100, pass=0.
- No channels enabled; start; done write -> pass=0. Cfg write during RUN is ignored (config readback via match behaviour unchanged).
- Abort on cycle 5 with all channels matched -> pass=0, cycles=5.
- Assert reset_b=0 mid-RUN -> busy/done/pass/match_vec=0 immediately; start after release with no reprogramming -> fail (config cleared).
